// File: rtl/led_fade_pwm.sv
`timescale 1ns/1ps
// NCH-channel LED PWM: shared 12-bit ramp, per-channel fade engine and an
// exponential/linear brightness curve, configured through an APB-style port.
module led_fade_pwm #(
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           psel,
    input  logic           penable,
    input  logic           pwrite,
    input  logic [7:0]     paddr,
    input  logic [7:0]     pwdata,
    output logic [7:0]     prdata,
    output logic           pready,
    input  logic [7:0]     manual_level,
    output logic [NCH-1:0] pwm_out,
    output logic           fade_busy,
    output logic           period_start
);

    localparam logic [7:0]  ADDR_CTRL = 8'h00;
    localparam logic [7:0]  ADDR_RATE = 8'h01;
    localparam logic [7:0]  ADDR_TGT  = 8'h10;
    localparam logic [7:0]  ADDR_CUR  = 8'h20;
    localparam logic [11:0] CNT_LAST  = 12'hFFF;

    logic           en;
    logic           src;
    logic           exp_mode;
    logic [7:0]     rate;
    logic [7:0]     div_cnt;
    logic [11:0]    cnt;
    logic [7:0]     target  [NCH];
    logic [7:0]     current [NCH];
    logic [11:0]    duty    [NCH];

    logic           wr_stb;
    logic           wr_ctrl;
    logic           wr_rate;
    logic [NCH-1:0] wr_tgt;
    logic           any_tgt_wr;
    logic           wrap;
    logic           step;

    // Level {e,m}: e==0 is a linear toe, otherwise a 6-bit mantissa shifted by e-1.
    function automatic logic [11:0] curve(input logic [7:0] lvl, input logic exp_sel);
        logic [11:0] mant;
        logic [2:0]  e;
        mant = {6'd0, 1'b1, lvl[4:0]};
        e    = lvl[7:5];
        if (!exp_sel)
            return {lvl, 4'b0000};
        else if (e == 3'd0)
            return {7'd0, lvl[4:0]};
        else
            return mant << (e - 3'd1);
    endfunction

    // ------------------------------------------------------------------
    // Register port decode
    // ------------------------------------------------------------------
    assign wr_stb  = psel & penable & pwrite;
    assign wr_ctrl = wr_stb && (paddr == ADDR_CTRL);
    assign wr_rate = wr_stb && (paddr == ADDR_RATE);
    assign pready  = 1'b1;

    always_comb begin
        wr_tgt = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_tgt[i] = wr_stb && (paddr == ADDR_TGT + 8'(i));
        end
    end

    assign any_tgt_wr = |wr_tgt;

    always_comb begin
        prdata = 8'h00;
        if (paddr == ADDR_CTRL)
            prdata = {5'b00000, exp_mode, src, en};
        else if (paddr == ADDR_RATE)
            prdata = rate;
        for (int i = 0; i < NCH; i++) begin
            if (paddr == ADDR_TGT + 8'(i))
                prdata = target[i];
            if (paddr == ADDR_CUR + 8'(i))
                prdata = current[i];
        end
    end

    // ------------------------------------------------------------------
    // Control, rate and target registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b1;
            src      <= 1'b0;
            exp_mode <= 1'b1;
            rate     <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                en       <= pwdata[0];
                src      <= pwdata[1];
                exp_mode <= pwdata[2];
            end else if (any_tgt_wr) begin
                src <= 1'b1;
            end
            if (wr_rate)
                rate <= pwdata;
        end
    end

    // A register write to a target takes priority over the manual follow path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                target[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_tgt[i])
                    target[i] <= pwdata;
                else if (!src)
                    target[i] <= manual_level;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ramp and wrap pulse
    // ------------------------------------------------------------------
    assign wrap = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 12'd0;
            period_start <= 1'b0;
        end else begin
            cnt          <= en ? cnt + 12'd1 : 12'd0;
            period_start <= wrap;
        end
    end

    // ------------------------------------------------------------------
    // Fade engine: divider counts wraps, one-code step on the RATE-th wrap
    // ------------------------------------------------------------------
    assign step = wrap && (rate != 8'd0) && (div_cnt >= rate - 8'd1) && !wr_rate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
        end else if (wr_rate) begin
            div_cnt <= 8'd0;
        end else if (wrap && (rate != 8'd0)) begin
            div_cnt <= (div_cnt >= rate - 8'd1) ? 8'd0 : div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                current[i] <= 8'h00;
        end else if (en) begin
            for (int i = 0; i < NCH; i++) begin
                if (rate == 8'd0) begin
                    current[i] <= target[i];
                end else if (step) begin
                    if (current[i] < target[i])
                        current[i] <= current[i] + 8'd1;
                    else if (current[i] > target[i])
                        current[i] <= current[i] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        fade_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (current[i] != target[i])
                fade_busy = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Duty shadow (reloaded only at the wrap) and output compare
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                duty[i] <= 12'd0;
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wrap)
                    duty[i] <= curve(current[i], exp_mode);
                pwm_out[i] <= en && (cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
`timescale 1ns/1ps
// Bench for led_fade_pwm: measures per-period high times and register readback
// against an arithmetic model of the brightness curve and fade rules.
module tb_led_fade_pwm;
    localparam int NCH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           psel = 1'b0;
    logic           penable = 1'b0;
    logic           pwrite = 1'b0;
    logic [7:0]     paddr = 8'h00;
    logic [7:0]     pwdata = 8'h00;
    logic [7:0]     manual_level = 8'h00;
    logic [7:0]     prdata;
    logic           pready;
    logic [NCH-1:0] pwm_out;
    logic           fade_busy;
    logic           period_start;

    int n_tests = 0;
    int n_fail  = 0;
    int lvl    [NCH];
    int exp_hi [NCH];
    int manual_a, manual_b, lvl2, n;
    logic [NCH-1:0] exp_vec;

    led_fade_pwm #(.NCH(NCH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .manual_level (manual_level),
        .pwm_out      (pwm_out),
        .fade_busy    (fade_busy),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic int curve_ref(input int l, input bit expm);
        int e, m;
        if (!expm) return l * 16;
        e = l / 32;
        m = l % 32;
        if (e == 0) return m;
        return (32 + m) * (2 ** (e - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input int expv);
        @(negedge clk);
        paddr = a;
        #1;
        check(tag, prdata, expv);
    endtask

    task automatic set_expect(input bit expm);
        for (int i = 0; i < NCH; i++) exp_hi[i] = curve_ref(lvl[i], expm);
    endtask

    task automatic wait_wrap(input string tag);
        int nw;
        nw = 0;
        @(negedge clk);
        while (period_start !== 1'b1 && nw < 5000) begin
            @(negedge clk);
            nw++;
        end
        check(tag, period_start, 1);
    endtask

    // Counts high cycles over one full period starting at the period_start cycle.
    task automatic measure(input string tag);
        int nw;
        int hi [NCH];
        nw = 0;
        while (period_start !== 1'b1 && nw < 5000) begin
            @(negedge clk);
            nw++;
        end
        check({tag, " wrap seen"}, period_start, 1);
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        for (int c = 0; c < 4096; c++) begin
            for (int i = 0; i < NCH; i++) if (pwm_out[i]) hi[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s ch%0d high", tag, i), hi[i], exp_hi[i]);
    endtask

    initial begin
        manual_a = $urandom_range(191, 1);
        manual_b = manual_a ^ 8'h5A;
        lvl2     = $urandom_range(255, 1);
        manual_level = 8'(manual_a);
        for (int i = 0; i < NCH; i++) lvl[i] = manual_a;

        // Reset state
        read_check("rst ctrl", 8'h00, 8'h05);
        read_check("rst rate", 8'h01, 0);
        read_check("rst tgt0", 8'h10, 0);
        read_check("rst cur4", 8'h24, 0);
        check("rst pwm", pwm_out, 0);
        check("rst pstart", period_start, 0);
        check("rst busy", fade_busy, 0);

        @(negedge clk);
        rst_n = 1'b1;
        set_expect(1'b1);
        measure("P1 manual");

        fork
            measure("P2 pre-write");
            begin
                repeat ($urandom_range(2500, 300)) @(negedge clk);
                read_check("cur2 manual", 8'h22, manual_a);
                read_check("unmapped tgt8", 8'h18, 0);
                check("busy idle", fade_busy, 0);
                apb_write(8'h13, 8'hFF);
                manual_level = 8'(manual_b);
                read_check("ctrl src set", 8'h00, 8'h07);
                read_check("tgt3", 8'h13, 8'hFF);
                repeat (5) @(negedge clk);
                read_check("tgt0 holds manual", 8'h10, manual_a);
            end
        join
        lvl[3] = 255;
        set_expect(1'b1);

        fork
            measure("P3 ch3 max");
            begin
                repeat ($urandom_range(3000, 200)) @(negedge clk);
                apb_write(8'h00, 8'h03);
                apb_write(8'h10, 8'h80);
                apb_write(8'h12, 8'(lvl2));
                apb_write(8'h17, 8'h00);
                read_check("ctrl exp off", 8'h00, 8'h03);
            end
        join
        lvl[0] = 128;
        lvl[2] = lvl2;
        lvl[7] = 0;
        set_expect(1'b0);
        measure("P4 linear");

        // Fade of ch1 from 0 to 4 at one step per two periods
        apb_write(8'h11, 8'h00);
        apb_write(8'h01, 8'h02);
        apb_write(8'h11, 8'h04);
        read_check("rate", 8'h01, 2);
        read_check("fade start cur1", 8'h21, 0);
        check("fade busy set", fade_busy, 1);
        for (int k = 1; k <= 8; k++) begin
            wait_wrap($sformatf("fade wrap%0d", k));
            read_check($sformatf("fade cur1 k%0d", k), 8'h21, k / 2);
            check($sformatf("fade busy k%0d", k), fade_busy, (k / 2 != 4));
        end
        lvl[1] = 4;

        // Disable mid-period, then re-enable
        apb_write(8'h01, 8'h00);
        repeat (200) @(negedge clk);
        check("ch0 high pre-disable", pwm_out[0], 1);
        apb_write(8'h00, 8'h02);
        @(negedge clk);
        check("en off pwm", pwm_out, 0);
        apb_write(8'h16, 8'hC0);
        repeat (10) @(negedge clk);
        read_check("cur6 frozen", 8'h26, lvl[6]);
        read_check("tgt6 written", 8'h16, 8'hC0);
        check("busy while frozen", fade_busy, 1);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (pwm_out != 0 || period_start) n++;
        end
        check("idle while disabled", n, 0);
        apb_write(8'h00, 8'h03);
        n = 0;
        while (period_start !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("restart period len", n, 4096);
        lvl[6] = 192;
        set_expect(1'b0);
        measure("P5 re-enable");

        // Asynchronous reset during an active fade
        apb_write(8'h01, 8'h01);
        apb_write(8'h15, 8'hFF);
        wait_wrap("rst-test wrap");
        repeat (100) @(negedge clk);
        for (int i = 0; i < NCH; i++) exp_vec[i] = (99 < curve_ref(lvl[i], 1'b0));
        check("pwm mid-period", pwm_out, exp_vec);
        read_check("cur5 stepped", 8'h25, lvl[5] + 1);
        check("busy mid-fade", fade_busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst pwm", pwm_out, 0);
        check("arst busy", fade_busy, 0);
        check("arst pstart", period_start, 0);
        paddr = 8'h25;
        #1;
        check("arst cur5", prdata, 0);
        paddr = 8'h00;
        #1;
        check("arst ctrl", prdata, 8'h05);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Parametrised successor to the 8-channel LED PWM block. It drives NCH PWM outputs from a shared 12-bit ramp and maps each 8-bit brightness level through a selectable exponential (perceptual) or linear curve. A per-channel fade engine steps each channel toward its target level at a programmable rate. It sits behind the I2C slave's APB-style register port, and falls back to a manual level input until the first register write.

## Interface

- NCH, 8, number of PWM channels, 1..16
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- psel  in  1  register select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- paddr  in  8  register address
- pwdata  in  8  write data
- prdata  out  8  read data, combinational from paddr
- pready  out  1  tied 1
- manual_level  in  8  level applied to all channels while SRC=0
- pwm_out  out  NCH  registered PWM outputs
- fade_busy  out  1  high while any channel's current level differs from its target
- period_start  out  1  one-cycle pulse when the ramp wraps to 0

## Operation

- Write strobe: psel & penable & pwrite.
- Register map:
  - 0x00 CTRL: [0] EN (reset 1), [1] SRC (reset 0; 0 = manual, 1 = registers), [2] EXP (reset 1). Bits [7:3] read 0.
  - 0x01 RATE (reset 0).
  - 0x10+i TARGET[i] (reset 0).
  - 0x20+i CURRENT[i], read-only (reset 0).
  - Unmapped addresses, and i >= NCH, read 0. Writes to them are ignored.
- Any write to TARGET[i] also sets SRC=1 in the same cycle. SRC returns to 0 only by a CTRL write.
- SRC=0: every cycle, all TARGET[i] <= manual_level.
- Ramp: 12-bit counter cnt, free-running 0..4095 while EN=1. While EN=0, cnt is held at 0 and CURRENT is frozen.
- Fade:
  - RATE=0: CURRENT[i] <= TARGET[i] every cycle.
  - RATE=R>0: a divider counts ramp wraps. On the R-th wrap it resets and issues a step: each CURRENT[i] moves one code toward TARGET[i] (+1 or -1, never overshooting).
  - A full 0->255 fade therefore takes 255*R periods.
- Curve, level L = {e[2:0], m[4:0]}:
  - EXP=1: D = (e==0) ? m : ({1'b1,m} << (e-1)). Range 0..4032, monotonic.
  - EXP=0: D = {L, 4'b0000}.
- Duty shadow: DUTY[i] loads curve(CURRENT[i]) only in the cycle cnt==4095, so no mid-period glitches. A CTRL.EXP change also takes effect only at the next wrap.
- Output: pwm_out[i] <= EN & (cnt < DUTY[i]).
- fade_busy = OR over i of (CURRENT[i] != TARGET[i]). Combinational.

## Timing

- Reset values: all registers as listed above; cnt=0, DUTY=0, divider=0; pwm_out=0; period_start=0.
- Register write is visible on prdata the cycle after the strobe.
- A TARGET change with RATE=0 reaches the pins at the start of the next ramp period, plus 1 cycle of output register latency.
- period_start is registered and high in the cycle cnt==0.
- PWM period is 4096 clk. High time is DUTY[i] clk, starting 1 cycle after cnt==0.
- Level 0 gives a constant 0. Maximum high time is 4032 (EXP) or 4080 (linear); the output is never constantly 1.
- EN 1->0: pwm_out goes 0 on the next cycle and cnt is 0.
- EN 0->1: the ramp restarts from 0, and DUTY reloads at the first wrap.
- TARGET written while a fade is in progress: the fade redirects toward the new target from the present CURRENT.
- RATE written mid-count: the divider resets to 0.
- Simultaneous SRC=0 manual update and TARGET write in the same cycle: the register write wins, and SRC becomes 1.
- Reset mid-period or mid-fade: everything returns to the reset values asynchronously.

## Test plan

- Reset, manual_level=0x20, EXP=1 -> after the first wrap, all channels are high 32 clk per 4096-clk period.
- Write TARGET[3]=0xFF -> SRC reads 1. Ch3 is high 4032 clk per period. Other channels keep the last manual level, and manual_level changes are ignored.
- CTRL=0x03 (EXP=0), TARGET[0]=0x80 -> ch0 high time is 2048 clk.
- RATE=2, TARGET[1] 0x00->0x04 -> CURRENT[1] steps every 2 periods and reaches 4 after 8 periods. fade_busy clears then.
- Write TARGET mid-period -> high time in the current period is unchanged; the new duty applies from the next cnt==0.
- EN=0 mid-period -> all outputs 0 next cycle, cnt held at 0. Assert rst_n low during an active fade -> CURRENT=0 and pwm_out=0 immediately.
